// File: rtl/pll_lock_monitor.sv
// Qualifies the raw PLL lock bit: stability filter, frequency window check,
// then continuous supervision while locked. Single clk_ref domain.
module pll_lock_monitor #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int WINDOW_CYCLES      = 256,
  parameter int EXP_COUNT          = 128,
  parameter int TOL                = 2,
  parameter int LOSS_FILTER        = 8,
  parameter int CNT_W              = 12
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             monitor_en,
  input  logic             pll_lock_raw,
  input  logic             pll_tick,
  input  logic             lock_lost_clr,
  output logic             pll_locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             freq_err,
  output logic [2:0]       mon_state
);

  localparam int SC_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int LOW_W = $clog2(LOSS_FILTER + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    MEASURE   = 3'd3,
    LOCKED    = 3'd4,
    LOST      = 3'd5
  } state_t;

  state_t           state;
  logic [SC_W-1:0]  stable_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic [LOW_W-1:0] low_cnt;
  logic             fail_seen;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (&cnt) return cnt;
    return cnt + CNT_W'(inc);
  endfunction

  function automatic logic out_of_tol(input logic [CNT_W-1:0] cnt);
    logic signed [CNT_W+1:0] dev;
    dev = $signed({2'b00, cnt}) - $signed((CNT_W+2)'(EXP_COUNT));
    if (dev[CNT_W+1]) dev = -dev;
    return (dev > $signed((CNT_W+2)'(TOL)));
  endfunction

  logic [CNT_W-1:0] win_sum;
  logic             win_last;
  logic             win_bad;
  logic             win_run;
  logic             glitch_loss;
  logic             drift_loss;

  always_comb begin
    win_sum     = sat_inc(tick_cnt, pll_tick);
    win_last    = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    win_bad     = out_of_tol(win_sum);
    // A raw drop abandons a measurement window but not a supervision window.
    win_run     = (state == LOCKED) || ((state == MEASURE) && pll_lock_raw);
    glitch_loss = !pll_lock_raw && (low_cnt == LOW_W'(LOSS_FILTER - 1));
    drift_loss  = win_last && win_bad && fail_seen;
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state      <= IDLE;
      stable_cnt <= '0;
      win_cnt    <= '0;
      tick_cnt   <= '0;
      low_cnt    <= '0;
      fail_seen  <= 1'b0;
      pll_locked <= 1'b0;
      lock_lost  <= 1'b0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      freq_err   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      // Clear first so a same-cycle loss below overrides it.
      if (lock_lost_clr) lock_lost <= 1'b0;

      if (!monitor_en) begin
        state      <= IDLE;
        pll_locked <= 1'b0;
      end else begin
        if (win_run) begin
          if (win_last) begin
            freq_count <= win_sum;
            freq_err   <= win_bad;
            freq_valid <= 1'b1;
            tick_cnt   <= '0;
            win_cnt    <= '0;
          end else begin
            tick_cnt <= win_sum;
            win_cnt  <= win_cnt + WIN_W'(1);
          end
        end

        case (state)
          IDLE: state <= WAIT_LOCK;
          WAIT_LOCK: begin
            if (pll_lock_raw) begin
              state      <= QUALIFY;
              stable_cnt <= '0;
            end
          end
          QUALIFY: begin
            if (!pll_lock_raw) begin
              state <= WAIT_LOCK;
            end else if (stable_cnt == SC_W'(LOCK_STABLE_CYCLES - 1)) begin
              state    <= MEASURE;
              win_cnt  <= '0;
              tick_cnt <= '0;
            end else begin
              stable_cnt <= stable_cnt + SC_W'(1);
            end
          end
          MEASURE: begin
            if (!pll_lock_raw) begin
              state <= WAIT_LOCK;
            end else if (win_last) begin
              fail_seen <= 1'b0;
              low_cnt   <= '0;
              if (win_bad) begin
                state <= WAIT_LOCK;
              end else begin
                state      <= LOCKED;
                pll_locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            low_cnt <= pll_lock_raw ? '0 : low_cnt + LOW_W'(1);
            if (win_last) fail_seen <= win_bad;
            if (glitch_loss || drift_loss) begin
              state      <= LOST;
              pll_locked <= 1'b0;
              lock_lost  <= 1'b1;
            end
          end
          LOST:    state <= WAIT_LOCK;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mon_state = state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: lock latency, glitch/loss filtering,
// frequency windows via a scoreboard of expected window results.
module tb_pll_lock_monitor;

  localparam int CNT_W = 12;

  logic             clk_ref;
  logic             rst;
  logic             monitor_en;
  logic             pll_lock_raw;
  logic             pll_tick;
  logic             lock_lost_clr;
  logic             pll_locked;
  logic             lock_lost;
  logic [CNT_W-1:0] freq_count;
  logic             freq_valid;
  logic             freq_err;
  logic [2:0]       mon_state;

  pll_lock_monitor #(
    .LOCK_STABLE_CYCLES(16),
    .WINDOW_CYCLES     (32),
    .EXP_COUNT         (8),
    .TOL               (1),
    .LOSS_FILTER       (4),
    .CNT_W             (CNT_W)
  ) dut (
    .clk_ref      (clk_ref),
    .rst          (rst),
    .monitor_en   (monitor_en),
    .pll_lock_raw (pll_lock_raw),
    .pll_tick     (pll_tick),
    .lock_lost_clr(lock_lost_clr),
    .pll_locked   (pll_locked),
    .lock_lost    (lock_lost),
    .freq_count   (freq_count),
    .freq_valid   (freq_valid),
    .freq_err     (freq_err),
    .mon_state    (mon_state)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  typedef struct packed {
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tick_mode = 4;
  int   tick_ph   = 0;

  // Tick patterns repeat every 48 cycles, so any 32-cycle window sees a fixed count:
  // mode 4 -> 8, mode 6 (3 ticks per 16) -> 6, mode 3 -> 10 or 11.
  function automatic logic tick_fn(input int mode, input int ph);
    case (mode)
      4:       return (ph % 4) == 0;
      3:       return (ph % 3) == 0;
      6:       return ((ph % 16) == 0) || ((ph % 16) == 5) || ((ph % 16) == 10);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int lo, input int hi, input logic err);
    exp_t e;
    e.lo  = CNT_W'(lo);
    e.hi  = CNT_W'(hi);
    e.err = err;
    sb_q.push_back(e);
  endtask

  // Drive the tick for the coming edge, then observe outputs on the falling edge.
  task automatic step();
    exp_t e;
    pll_tick = tick_fn(tick_mode, tick_ph);
    tick_ph  = (tick_ph + 1) % 48;
    @(negedge clk_ref);
    if (freq_valid === 1'b1) begin
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_empty observed=%0d expected=nonzero", sb_q.size());
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        assert ((freq_count >= e.lo) && (freq_count <= e.hi)) else begin
          n_fail++;
          $error("FAIL freq_count observed=%0d expected=%0d..%0d", freq_count, e.lo, e.hi);
        end
        chk("freq_err_sb", 32'(freq_err), 32'(e.err));
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_locked(input int bound, output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      n++;
      if (pll_locked === 1'b1) break;
    end
  endtask

  task automatic run_to_window(input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (freq_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("window_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    monitor_en    = 1'b0;
    pll_lock_raw  = 1'b0;
    pll_tick      = 1'b0;
    lock_lost_clr = 1'b0;
    steps(3);
    chk("rst_pll_locked", 32'(pll_locked), 0);
    chk("rst_lock_lost",  32'(lock_lost),  0);
    chk("rst_freq_count", 32'(freq_count), 0);
    chk("rst_freq_valid", 32'(freq_valid), 0);
    chk("rst_freq_err",   32'(freq_err),   0);
    chk("rst_state",      32'(mon_state),  0);
    rst = 1'b0;

    // Nominal lock
    monitor_en = 1'b1;
    step();
    chk("nom_wait_lock", 32'(mon_state), 1);
    pll_lock_raw = 1'b1;
    push_exp(8, 8, 1'b0);
    wait_locked(200, n);
    chk("nom_latency",   n, 49);
    chk("nom_state",     32'(mon_state),  4);
    chk("nom_count",     32'(freq_count), 8);
    chk("nom_lock_lost", 32'(lock_lost),  0);
    step();
    chk("nom_valid_pulse", 32'(freq_valid), 0);

    // Loss filter: 3 low cycles ignored, 4 declare loss
    pll_lock_raw = 1'b0;
    steps(3);
    pll_lock_raw = 1'b1;
    step();
    chk("glitch3_locked", 32'(pll_locked), 1);
    chk("glitch3_state",  32'(mon_state),  4);
    pll_lock_raw = 1'b0;
    steps(4);
    chk("loss4_locked",    32'(pll_locked), 0);
    chk("loss4_lock_lost", 32'(lock_lost),  1);
    chk("loss4_state",     32'(mon_state),  5);
    step();
    chk("lost_to_wait", 32'(mon_state), 1);
    pll_lock_raw = 1'b1;
    push_exp(8, 8, 1'b0);
    wait_locked(200, n);
    chk("requal_latency", n, 49);

    // Disable while locked keeps the sticky flag
    monitor_en = 1'b0;
    step();
    chk("dis_state",     32'(mon_state),  0);
    chk("dis_locked",    32'(pll_locked), 0);
    chk("dis_lock_lost", 32'(lock_lost),  1);
    monitor_en = 1'b1;
    push_exp(8, 8, 1'b0);
    wait_locked(200, n);
    chk("reen_latency", n, 50);

    // Sticky clear
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    chk("clr_lock_lost", 32'(lock_lost), 0);

    // Frequency drift while locked
    push_exp(8, 8, 1'b0);
    run_to_window(100);
    tick_mode = 6;
    push_exp(6, 6, 1'b1);
    run_to_window(100);
    chk("drift1_locked",    32'(pll_locked), 1);
    chk("drift1_state",     32'(mon_state),  4);
    chk("drift1_lock_lost", 32'(lock_lost),  0);
    lock_lost_clr = 1'b1;
    push_exp(6, 6, 1'b1);
    run_to_window(100);
    chk("drift2_state",     32'(mon_state),  5);
    chk("drift2_locked",    32'(pll_locked), 0);
    chk("drift2_set_wins",  32'(lock_lost),  1);
    step();
    lock_lost_clr = 1'b0;
    chk("drift2_clr", 32'(lock_lost), 0);
    chk("drift2_wait", 32'(mon_state), 1);

    // Frequency too high: never locks, retries
    tick_mode = 3;
    push_exp(10, 11, 1'b1);
    run_to_window(200);
    chk("fail1_state",  32'(mon_state),  1);
    chk("fail1_locked", 32'(pll_locked), 0);
    step();
    chk("fail_retry_qualify", 32'(mon_state), 2);
    push_exp(10, 11, 1'b1);
    run_to_window(200);
    chk("fail2_state",  32'(mon_state),  1);
    chk("fail2_locked", 32'(pll_locked), 0);

    // Qualify glitch at stable_cnt=10
    tick_mode    = 4;
    pll_lock_raw = 1'b0;
    step();
    chk("qg_wait", 32'(mon_state), 1);
    pll_lock_raw = 1'b1;
    step();
    chk("qg_qualify", 32'(mon_state), 2);
    steps(10);
    pll_lock_raw = 1'b0;
    step();
    chk("qg_back_wait", 32'(mon_state), 1);
    pll_lock_raw = 1'b1;
    push_exp(8, 8, 1'b0);
    wait_locked(200, n);
    chk("qg_latency", n, 49);

    // Reset in MEASURE
    pll_lock_raw = 1'b0;
    steps(4);
    chk("pre_rst_lock_lost", 32'(lock_lost), 1);
    pll_lock_raw = 1'b1;
    steps(18);
    chk("measure_entry", 32'(mon_state), 3);
    steps(5);
    chk("measure_hold", 32'(mon_state), 3);
    rst = 1'b1;
    step();
    chk("mrst_pll_locked", 32'(pll_locked), 0);
    chk("mrst_lock_lost",  32'(lock_lost),  0);
    chk("mrst_freq_count", 32'(freq_count), 0);
    chk("mrst_freq_valid", 32'(freq_valid), 0);
    chk("mrst_freq_err",   32'(freq_err),   0);
    chk("mrst_state",      32'(mon_state),  0);
    rst = 1'b0;
    step();

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
